// File: rtl/line_render_pkg.sv
// Shared types and helpers for the HUB75 line renderer: FSM states, rgb bit
// positions and the per-channel PWM comparison.
package line_render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    // Bit positions on the panel's 6-wire colour bus, {b1,g1,r1,b0,g0,r0}.
    localparam int RGB_R0 = 0;
    localparam int RGB_G0 = 1;
    localparam int RGB_B0 = 2;
    localparam int RGB_R1 = 3;
    localparam int RGB_G1 = 4;
    localparam int RGB_B1 = 5;

    // Widest channel intensity the comparator helper accepts.
    localparam int BCM_MAX_W = 16;

    // A channel is lit when its intensity strictly exceeds the threshold,
    // so intensity 0 is always dark.
    function automatic logic bcm_bit(input logic [BCM_MAX_W-1:0] value,
                                     input logic [BCM_MAX_W-1:0] threshold);
        return value > threshold;
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// Six-lane intensity-vs-threshold comparator; purely combinational, the
// parent registers the result onto the panel bus.
module pwm_compare
    import line_render_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic [6*DEPTH-1:0] i_mem_data,
    input  logic [DEPTH-1:0]   i_pwm,
    output logic [5:0]         o_rgb
);

    logic [BCM_MAX_W-1:0] w_thr;

    assign w_thr = BCM_MAX_W'(i_pwm);

    assign o_rgb[RGB_R0] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_R0*DEPTH +: DEPTH]), w_thr);
    assign o_rgb[RGB_G0] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_G0*DEPTH +: DEPTH]), w_thr);
    assign o_rgb[RGB_B0] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_B0*DEPTH +: DEPTH]), w_thr);
    assign o_rgb[RGB_R1] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_R1*DEPTH +: DEPTH]), w_thr);
    assign o_rgb[RGB_G1] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_G1*DEPTH +: DEPTH]), w_thr);
    assign o_rgb[RGB_B1] = bcm_bit(BCM_MAX_W'(i_mem_data[RGB_B1*DEPTH +: DEPTH]), w_thr);

endmodule

// File: rtl/line_render_pwm.sv
// HUB75 line renderer: fetches one framebuffer row and shifts PWM-thresholded
// colour bits to the column drivers, two clocks per pixel.
module line_render_pwm
    import line_render_pkg::*;
#(
    parameter int PX_PER_ROW = 80,
    parameter int DEPTH      = 7,
    parameter int ROW_BITS   = 5,
    parameter int MEM_AW     = ROW_BITS + $clog2(PX_PER_ROW)
) (
    input  logic                 clk_25MHz,
    input  logic                 rst,
    input  logic                 begin_in,
    output logic                 done_out,
    input  logic [ROW_BITS-1:0]  addr,
    input  logic [DEPTH-1:0]     pwm,
    output logic                 mem_rd_en,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic [6*DEPTH-1:0]   mem_data,
    output logic                 rgb_clk,
    output logic [5:0]           rgb
);

    localparam int               COL_W    = $clog2(PX_PER_ROW);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PX_PER_ROW - 1);

    state_t             r_state,    w_state_nxt;
    logic [COL_W-1:0]   r_col,      w_col_nxt;
    logic [DEPTH-1:0]   r_pwm,      w_pwm_nxt;
    logic [MEM_AW-1:0]  r_base,     w_base_nxt;
    logic [MEM_AW-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic               r_rd_en,    w_rd_en_nxt;
    logic               r_rgb_clk,  w_rgb_clk_nxt;
    logic [5:0]         r_rgb,      w_rgb_nxt;
    logic               r_done,     w_done_nxt;

    logic [MEM_AW-1:0]  w_row_base;
    logic [COL_W-1:0]   w_col_inc;
    logic [5:0]         w_rgb_cmp;

    // Row base by a constant factor: reduces to shifts and adds.
    assign w_row_base = MEM_AW'(addr) * MEM_AW'(PX_PER_ROW);
    assign w_col_inc  = r_col + COL_W'(1);

    pwm_compare #(
        .DEPTH      (DEPTH)
    ) u_pwm_compare (
        .i_mem_data (mem_data),
        .i_pwm      (r_pwm),
        .o_rgb      (w_rgb_cmp)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_pwm_nxt      = r_pwm;
        w_base_nxt     = r_base;
        w_mem_addr_nxt = r_mem_addr;
        w_rd_en_nxt    = 1'b0;
        w_rgb_clk_nxt  = r_rgb_clk;
        w_rgb_nxt      = r_rgb;
        w_done_nxt     = r_done;

        if (begin_in) begin
            w_state_nxt    = FETCH;
            w_col_nxt      = '0;
            w_pwm_nxt      = pwm;
            w_base_nxt     = w_row_base;
            w_mem_addr_nxt = w_row_base;
            w_rd_en_nxt    = 1'b1;
            w_rgb_clk_nxt  = 1'b0;
            w_done_nxt     = 1'b0;
        end else begin
            unique case (r_state)
                IDLE:  ;
                FETCH: w_state_nxt = LOW;
                LOW: begin
                    w_rgb_nxt     = w_rgb_cmp;
                    w_rgb_clk_nxt = 1'b0;
                    w_state_nxt   = HIGH;
                    if (r_col != LAST_COL) begin
                        w_col_nxt      = w_col_inc;
                        w_mem_addr_nxt = r_base + MEM_AW'(w_col_inc);
                        w_rd_en_nxt    = 1'b1;
                    end
                end
                HIGH: begin
                    w_rgb_clk_nxt = 1'b1;
                    // A read left pending by the preceding LOW means more pixels follow.
                    w_state_nxt   = r_rd_en ? LOW : DONE;
                end
                DONE: begin
                    w_rgb_clk_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_pwm      <= '0;
            r_base     <= '0;
            r_mem_addr <= '0;
            r_rd_en    <= 1'b0;
            r_rgb_clk  <= 1'b0;
            r_rgb      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_pwm      <= w_pwm_nxt;
            r_base     <= w_base_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rgb_clk  <= w_rgb_clk_nxt;
            r_rgb      <= w_rgb_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign done_out  = r_done;
    assign mem_rd_en = r_rd_en;
    assign mem_addr  = r_mem_addr;
    assign rgb_clk   = r_rgb_clk;
    assign rgb       = r_rgb;

endmodule
